// File: rtl/mdu_seq_if.sv
// Request/response bus for the sequential multiply/divide unit.
// Handshake: a transfer happens on the rising edge where valid && ready are
// both 1; the producer keeps valid and payload stable until that edge, and
// ready may depend combinationally on the consumer's state (and i_flush).
interface mdu_seq_if;
  logic        i_flush;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_req_op;
  logic [31:0] i_req_a;
  logic [31:0] i_req_b;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_data;
  logic        o_busy;

  modport master (
    output i_flush, i_req_valid, i_req_op, i_req_a, i_req_b, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_data, o_busy
  );

  modport slave (
    input  i_flush, i_req_valid, i_req_op, i_req_a, i_req_b, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_data, o_busy
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit. Multiplies and trivial divides
// (b==0, signed overflow) finish in one cycle; other divides run a 32-step
// restoring shift-subtract on operand magnitudes, with the sign fixed when
// leaving CALC. dbg_state exposes the FSM state for checkers.
module mdu_seq #(
  parameter int ENABLE_MUL = 1,
  parameter int ENABLE_DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mdu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_n;
  logic [31:0] res_q, res_n;
  logic        accept;
  logic        a_ext, b_ext;
  logic [63:0] prod;
  logic [31:0] mul_res;
  logic        div_zero, div_ovf;
  logic [31:0] fast_div_res;
  logic        calc_last;
  logic [31:0] calc_res;

  assign bus.o_req_ready  = (state_q == IDLE) && !bus.i_flush;
  assign bus.o_resp_valid = (state_q == DONE);
  assign bus.o_resp_data  = res_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign dbg_state        = state_q;
  assign accept           = bus.i_req_valid && bus.o_req_ready;

  // Single-cycle results: 64-bit product with per-op sign extension, and
  // the divide-by-zero / overflow shortcuts.
  always_comb begin
    a_ext   = (bus.i_req_op == 3'd1 || bus.i_req_op == 3'd2) ? bus.i_req_a[31] : 1'b0;
    b_ext   = (bus.i_req_op == 3'd1) ? bus.i_req_b[31] : 1'b0;
    prod    = {{32{a_ext}}, bus.i_req_a} * {{32{b_ext}}, bus.i_req_b};
    mul_res = (bus.i_req_op[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
    if (ENABLE_MUL == 0) mul_res = 32'h0;
    div_zero = (bus.i_req_b == 32'h0);
    div_ovf  = !bus.i_req_op[0] && (bus.i_req_a == 32'h8000_0000) &&
               (bus.i_req_b == 32'hFFFF_FFFF);
    if (div_zero)
      fast_div_res = bus.i_req_op[1] ? bus.i_req_a : 32'hFFFF_FFFF;
    else
      fast_div_res = bus.i_req_op[1] ? 32'h0 : 32'h8000_0000;
  end

  // Next-state and result register update; flush overrides everything but reset.
  always_comb begin
    state_n = state_q;
    res_n   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.i_req_op[2]) begin
            state_n = DONE;
            res_n   = mul_res;
          end else if (ENABLE_DIV == 0) begin
            state_n = DONE;
            res_n   = 32'h0;
          end else if (div_zero || div_ovf) begin
            state_n = DONE;
            res_n   = fast_div_res;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        if (calc_last) begin
          state_n = DONE;
          res_n   = calc_res;
        end
      end
      DONE: begin
        if (bus.i_resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (bus.i_flush) state_n = IDLE;
  end

  // State and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_n;
      res_q   <= res_n;
    end
  end

  if (ENABLE_DIV != 0) begin : g_div
    logic [31:0] rem_q, quo_q, dvs_q;
    logic [5:0]  cnt_q;
    logic        neg_quo_q, neg_rem_q, is_rem_q;
    logic        sgn;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted, diff;
    logic [31:0] rem_n, quo_n;

    // Operand magnitudes, one restoring step, and the sign-corrected result.
    always_comb begin
      sgn     = !bus.i_req_op[0];
      abs_a   = (sgn && bus.i_req_a[31]) ? -bus.i_req_a : bus.i_req_a;
      abs_b   = (sgn && bus.i_req_b[31]) ? -bus.i_req_b : bus.i_req_b;
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
      if (!diff[32]) begin
        rem_n = diff[31:0];
        quo_n = {quo_q[30:0], 1'b1};
      end else begin
        rem_n = shifted[31:0];
        quo_n = {quo_q[30:0], 1'b0};
      end
      if (is_rem_q) calc_res = neg_rem_q ? -rem_n : rem_n;
      else          calc_res = neg_quo_q ? -quo_n : quo_n;
    end

    assign calc_last = (state_q == CALC) && (cnt_q == 6'd31);

    // Divider datapath: load on accept, iterate while in CALC.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rem_q     <= 32'h0;
        quo_q     <= 32'h0;
        dvs_q     <= 32'h0;
        cnt_q     <= 6'd0;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
        is_rem_q  <= 1'b0;
      end else if (state_q == IDLE) begin
        cnt_q <= 6'd0;
        if (accept && bus.i_req_op[2]) begin
          rem_q     <= 32'h0;
          quo_q     <= abs_a;
          dvs_q     <= abs_b;
          neg_quo_q <= sgn && (bus.i_req_a[31] ^ bus.i_req_b[31]);
          neg_rem_q <= sgn && bus.i_req_a[31];
          is_rem_q  <= bus.i_req_op[1];
        end
      end else if (state_q == CALC) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end else begin : g_no_div
    assign calc_last = 1'b0;
    assign calc_res  = 32'h0;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: hand-computed RV32M results, latencies,
// hold/handshake behaviour, flush and reset aborts.
module tb_mdu_seq;
  logic       i_clk;
  logic       i_rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;

  mdu_seq_if bus ();

  mdu_seq dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request starting #1 after an edge; it is accepted at the next
  // edge. Afterwards the request inputs are scrambled to show they are ignored.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = op;
    bus.i_req_a     = a;
    bus.i_req_b     = b;
    @(posedge i_clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_op    = 3'($urandom_range(0, 7));
    bus.i_req_a     = $urandom;
    bus.i_req_b     = $urandom;
  endtask

  // Wait for o_resp_valid, checking busy on the way; latency counts the
  // accept edge as 1.
  task automatic wait_resp(input string tag, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    lat = 1;
    while (bus.o_resp_valid !== 1'b1 && lat < 60) begin
      check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      @(posedge i_clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, bus.o_resp_data, exp_data);
  endtask

  task automatic handshake(input string tag);
    bus.i_resp_ready = 1'b1;
    check({tag, "_rdy_in_hs"}, 32'(bus.o_req_ready), 32'd0);
    @(posedge i_clk);
    #1;
    bus.i_resp_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(bus.o_resp_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_idle_rdy"}, 32'(bus.o_req_ready), 32'd1);
  endtask

  task automatic op_test(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    send(op, a, b);
    wait_resp(tag, exp, lat);
    handshake(tag);
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_resp_valid === 1'b1) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    i_rst            = 1'b1;
    bus.i_flush      = 1'b0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_op     = 3'd0;
    bus.i_req_a      = 32'h0;
    bus.i_req_b      = 32'h0;
    bus.i_resp_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset state.
    check("rst_valid", 32'(bus.o_resp_valid), 32'd0);
    check("rst_data", bus.o_resp_data, 32'h0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_rdy", 32'(bus.o_req_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Multiplies.
    op_test("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    op_test("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    op_test("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    op_test("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    op_test("mul_big", 3'd0, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1);
    op_test("mulhu_big", 3'd3, 32'h0001_0000, 32'h0001_0003, 32'h0000_0001, 1);

    // Iterative divides.
    op_test("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    op_test("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    op_test("div_20_m3", 3'd4, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    op_test("rem_20_m3", 3'd6, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    op_test("divu_max_1", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    op_test("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    // Shortcut divides.
    op_test("divu_z", 3'd5, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
    op_test("remu_z", 3'd7, 32'd123, 32'd0, 32'd123, 1);
    op_test("rem_m5_z", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    op_test("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op_test("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Response held while consumer stalls.
    send(3'd5, 32'd100, 32'd7);
    wait_resp("divu_hold", 32'd14, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      check("hold_valid", 32'(bus.o_resp_valid), 32'd1);
      check("hold_data", bus.o_resp_data, 32'd14);
    end
    handshake("divu_hold");

    // Flush during CALC at cycle T+10.
    send(3'd5, 32'd1000, 32'd3);
    repeat (9) @(posedge i_clk);
    #1;
    check("flush_calc_state", 32'(dbg_state), 32'd1);
    bus.i_flush = 1'b1;
    check("flush_rdy_mask", 32'(bus.o_req_ready), 32'd0);
    @(posedge i_clk);
    #1;
    bus.i_flush = 1'b0;
    check("flush_state", 32'(dbg_state), 32'd0);
    check("flush_busy", 32'(bus.o_busy), 32'd0);
    no_pulse("flush_no_pulse", 40);
    op_test("mul_3_5", 3'd0, 32'd3, 32'd5, 32'd15, 1);

    // Flush in DONE beats the handshake.
    send(3'd0, 32'd6, 32'd7);
    check("flushd_valid", 32'(bus.o_resp_valid), 32'd1);
    bus.i_flush      = 1'b1;
    bus.i_resp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_flush      = 1'b0;
    bus.i_resp_ready = 1'b0;
    check("flushd_state", 32'(dbg_state), 32'd0);
    check("flushd_valid_gone", 32'(bus.o_resp_valid), 32'd0);

    // Reset pulse mid-CALC.
    send(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midrst_valid", 32'(bus.o_resp_valid), 32'd0);
    check("midrst_data", bus.o_resp_data, 32'h0);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_rdy", 32'(bus.o_req_ready), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'd0);
    no_pulse("midrst_no_pulse", 40);

    // Request held with flush asserted is never accepted.
    bus.i_flush     = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = 3'd0;
    bus.i_req_a     = 32'd2;
    bus.i_req_b     = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      check("flushreq_busy", 32'(bus.o_busy), 32'd0);
      check("flushreq_rdy", 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_req_valid = 1'b0;
    bus.i_flush     = 1'b0;
    @(posedge i_clk);
    #1;
    check("flushreq_valid", 32'(bus.o_resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
